// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drain stage for the synchronous FIFO. Pops one word whenever
// the FIFO is non-empty and enable is high (only while idle), then serialises
// it as one start bit (0), DATA_W data bits LSB first, and one stop bit (1),
// each lasting CLKS_PER_BIT clocks.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-low reset
//   enable      permits starting a new frame (only looked at in IDLE)
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO data_out, valid the cycle after fifo_r_en
//   fifo_r_en   FIFO read strobe (combinational, one cycle per frame)
//   tx          serial line, registered, idles high
//   busy        registered, high whenever the FSM is not IDLE
//   frame_done  registered one-cycle pulse in the last stop-bit cycle
module fifo_uart_tx #(
  parameter int DATA_W       = 16,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_r_en,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_d, busy_d, done_d;
  logic              bit_end;

  assign bit_end = (cyc_q == CYC_LAST);

  // State register plus the datapath registers that travel with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cyc_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx         <= tx_d;
      busy       <= busy_d;
      frame_done <= done_d;
    end
  end

  // Next-state and datapath. tx_d is the line level for the next cycle, so
  // each bit boundary loads the value of the bit that starts there.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (fifo_r_en) state_d = LOAD;
      end
      LOAD: begin
        shift_d = fifo_data;
        tx_d    = 1'b0;
        cyc_d   = '0;
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          cyc_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cyc_d   = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + BW'(1);
          if (bit_q == BIT_LAST) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            // shift_q[1] becomes shift_d[0], the next data bit.
            tx_d = shift_q[1];
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          cyc_d   = '0;
          state_d = IDLE;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs. busy/frame_done are registered, so they are computed from the
  // next state; frame_done flags the cycle in which STOP sits on its last count.
  always_comb begin
    fifo_r_en = rst && (state_q == IDLE) && enable && !fifo_empty;
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == STOP) && (cyc_d == CYC_LAST);
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream drain stage for the 16-bit synchronous FIFO. It pops one word whenever the FIFO is non-empty and transmission is enabled, then serialises the word onto a single UART-style line: one start bit, 16 data bits LSB first, one stop bit. It drives the FIFO's read enable directly and consumes its data_out and empty outputs.

Parameters:
DATA_W, 16, word width; must match the FIFO data width.
CLKS_PER_BIT, 4, clock cycles per serial bit; legal range 1 to 65535.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  synchronous, active-low reset; rst=0 at a rising edge resets the block.
enable  input  1  permits starting a new frame; sampled only in IDLE.
fifo_empty  input  1  FIFO empty flag.
fifo_data  input  DATA_W  FIFO data_out; valid in the cycle after a read strobe.
fifo_r_en  output  1  FIFO read strobe; combinational, at most one cycle per frame.
tx  output  1  serial line; registered; idles high.
busy  output  1  high whenever state is not IDLE; registered.
frame_done  output  1  single-cycle pulse during the last cycle of the stop bit; registered.

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE, tx=1, busy=0, frame_done=0, bit counter=0, cycle counter=0, shift register=0.
  - fifo_r_en=0 while rst=0.
  - Reset mid-frame aborts the frame; tx returns to 1 at that edge. No partial word is retained.
- FSM states: IDLE, LOAD, START, DATA, STOP.
- IDLE:
  - fifo_r_en = enable && !fifo_empty.
  - If fifo_r_en=1, go to LOAD at the next edge; otherwise stay in IDLE.
  - fifo_r_en is never asserted while fifo_empty=1.
- LOAD (1 cycle):
  - fifo_data is valid in this cycle.
  - At the edge: capture fifo_data into the shift register, set tx=0, clear the cycle counter, go to START.
- START:
  - tx=0 for CLKS_PER_BIT cycles.
  - Then drive tx = shift[0], set bit counter=0, go to DATA.
- DATA:
  - Each bit lasts CLKS_PER_BIT cycles.
  - At the end of each bit, shift right by one and increment the bit counter.
  - After bit DATA_W-1 completes, set tx=1 and go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - frame_done=1 in the final cycle only.
  - Then go to IDLE.
- Timing (cycle 0 = IDLE cycle with fifo_r_en=1; C = CLKS_PER_BIT):
  - LOAD is cycle 1.
  - Start bit occupies cycles 2 .. 2+C-1.
  - Data bit i occupies cycles 2+C*(1+i) .. 2+C*(2+i)-1.
  - Stop bit occupies cycles 2+17C .. 2+18C-1.
  - Frame length is 18C line cycles plus 2 overhead cycles.
- Back-to-back frames: the IDLE cycle after STOP may assert fifo_r_en immediately. The minimum inter-frame gap is 2 cycles with tx=1 (IDLE and LOAD).
- enable:
  - Deasserting enable mid-frame has no effect; the current frame completes.
  - enable only gates the IDLE-to-LOAD transition.
- fifo_empty changing mid-frame is ignored; the word is already latched.
- Counters:
  - Cycle counter width is clog2(CLKS_PER_BIT) bits, minimum 1.
  - Bit counter width is clog2(DATA_W) bits.
  - With CLKS_PER_BIT=1, each bit lasts exactly one cycle.
- The block only reads, so FIFO full has no effect on it.

Test Plan:
- Reset: hold rst=0 for 2 cycles with fifo_empty=0 and enable=1 -> fifo_r_en=0, tx=1, busy=0, frame_done=0 throughout; the first fifo_r_en pulse occurs in the first cycle after rst=1.
- Single word, C=4, fifo_data=16'd32 (16'h0020):
  - Stimulus: fifo_r_en pulse in cycle 0.
  - Response: tx=0 in cycles 2-5; data bit 5 (=1) in cycles 26-29; all other data bits 0; tx=1 in cycles 70-73; frame_done=1 only in cycle 73; busy=0 from cycle 74.
- Three words 32, 12, 5 queued with enable=1:
  - Response: exactly 3 fifo_r_en pulses, 74 cycles apart.
  - Decoded LSB-first words are 0x0020, 0x000C, 0x0005.
  - A 2-cycle tx=1 gap separates frames; no pulse occurs once fifo_empty=1.
- Empty and enable gating:
  - fifo_empty=1 with enable=1 -> no fifo_r_en and tx stays 1.
  - enable=0 with fifo_empty=0 -> no fifo_r_en.
  - enable dropped at cycle 10 of a frame -> the frame still completes and no new pop occurs.
- Reset mid-frame: rst=0 at cycle 30 -> tx=1 and busy=0 after that edge; after release, the next queued word pops and transmits in full.
- C=1 and fifo_data=16'hFFFF -> tx=0 for 1 cycle, then 1 for 17 cycles; frame_done appears 19 cycles after the pop.
